// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master round-robin arbiter for the PicoRV32 native bus.
// Define ARB_TIMEOUT_EN to enable the bus-timeout watchdog.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  input  logic        s_ready,
  output logic [1:0]  grant,
  input  logic        err_clr,
  output logic        timeout_err,
  output logic [31:0] err_addr
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        busy;
  logic        sel_valid;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wstrb;
  logic        done;
  logic        tmo;
  logic        rsp;
  logic [31:0] rsp_data;

  assign busy = (state_q == BUSY);

  always_comb begin
    sel_valid = m0_valid;
    sel_addr  = m0_addr;
    sel_wdata = m0_wdata;
    sel_wstrb = m0_wstrb;
    if (owner_q) begin
      sel_valid = m1_valid;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
      sel_wstrb = m1_wstrb;
    end
  end

  // Non-owner inputs never reach the slave side; idle bus is all zero
  always_comb begin
    s_valid = busy & sel_valid;
    s_addr  = busy ? sel_addr  : 32'h0;
    s_wdata = busy ? sel_wdata : 32'h0;
    s_wstrb = busy ? sel_wstrb : 4'h0;
    grant   = busy ? {owner_q, ~owner_q} : 2'b00;
  end

  assign done     = s_valid & s_ready;
  assign rsp      = done | tmo;
  assign rsp_data = done ? s_rdata : ERR_RDATA;

  always_comb begin
    m0_ready = rsp & ~owner_q;
    m1_ready = rsp & owner_q;
    m0_rdata = m0_ready ? rsp_data : 32'h0;
    m1_rdata = m1_ready ? rsp_data : 32'h0;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_valid | m1_valid) begin
          state_d = BUSY;
          owner_d = (m0_valid & m1_valid) ? ~last_q : m1_valid;
        end
      end
      BUSY: begin
        // A dropped request aborts without touching the fairness pointer
        if (!s_valid) begin
          state_d = IDLE;
        end else if (rsp) begin
          state_d = IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] timer_q, timer_d;
  logic        err_q, err_d;
  logic [31:0] err_addr_q, err_addr_d;

  assign tmo = s_valid & ~s_ready & (timer_q == TMO_LAST);

  always_comb begin
    timer_d    = 16'h0;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (busy & s_valid & ~s_ready & ~tmo) begin
      timer_d = timer_q + 16'h1;
    end
    if (tmo) begin
      err_d      = 1'b1;
      err_addr_d = s_addr;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_q    <= 16'h0;
      err_q      <= 1'b0;
      err_addr_q <= 32'h0;
    end else begin
      timer_q    <= timer_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign timeout_err = err_q;
  assign err_addr    = err_addr_q;
`else
  logic [32:0] unused_cfg;

  assign unused_cfg  = {err_clr, 32'(TIMEOUT_CYCLES)};
  assign tmo         = 1'b0;
  assign timeout_err = 1'b0;
  assign err_addr    = 32'h0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        v[2];
  logic [31:0] a[2];
  logic [31:0] wd[2];
  logic [3:0]  ws[2];
  logic [31:0] rd0, rd1;
  logic        rdy0, rdy1;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [31:0] s_rdata;
  logic        s_ready;
  logic [1:0]  grant;
  logic        err_clr;
  logic        timeout_err;
  logic [31:0] err_addr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(v[0]), .m0_addr(a[0]), .m0_wdata(wd[0]), .m0_wstrb(ws[0]),
    .m0_rdata(rd0), .m0_ready(rdy0),
    .m1_valid(v[1]), .m1_addr(a[1]), .m1_wdata(wd[1]), .m1_wstrb(ws[1]),
    .m1_rdata(rd1), .m1_ready(rdy1),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rdata(s_rdata), .s_ready(s_ready), .grant(grant),
    .err_clr(err_clr), .timeout_err(timeout_err), .err_addr(err_addr)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    resetn  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; a[i] = 32'h0; wd[i] = 32'h0; ws[i] = 4'h0;
    end
    s_ready = 1'b0;
    s_rdata = 32'h0;
    err_clr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_svalid", s_valid, 1'b0);
    chk("rst_rdy", {rdy1, rdy0}, 2'b00);
    chk("rst_rdata", rd0 | rd1, 32'h0);
    chk("rst_err", timeout_err, 1'b0);
    chk("rst_eaddr", err_addr, 32'h0);
    resetn = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  bit          mbusy;
  int          mown, mlast, mtimer;
  bit          merr;
  logic [31:0] merr_addr;
  bit          ev, etmo;
  logic        erdy[2];
  logic [31:0] erd[2];

  initial begin
    // read from m0, slave answers on the first s_valid cycle
    do_reset();
    v[0] = 1'b1; a[0] = 32'h0000_0010; ws[0] = 4'h0;
    s_ready = 1'b1; s_rdata = 32'h1234_5678;
    #1;
    chk("t1_idle_grant", grant, 2'b00);
    chk("t1_idle_rdy", rdy0, 1'b0);
    step();
    chk("t1_grant", grant, 2'b01);
    chk("t1_saddr", s_addr, 32'h0000_0010);
    chk("t1_rdy0", rdy0, 1'b1);
    chk("t1_rdata0", rd0, 32'h1234_5678);
    chk("t1_rdy1", rdy1, 1'b0);
    v[0] = 1'b0;
    step();
    chk("t1_after", s_valid, 1'b0);

    // m1 write passes through exactly
    do_reset();
    v[1] = 1'b1; a[1] = 32'h8000_0000; wd[1] = 32'h3F; ws[1] = 4'hF;
    a[0] = 32'h1111_1111; wd[0] = 32'h2222_2222; ws[0] = 4'h3;
    s_ready = 1'b1;
    step();
    chk("t3_grant", grant, 2'b10);
    chk("t3_saddr", s_addr, 32'h8000_0000);
    chk("t3_swdata", s_wdata, 32'h3F);
    chk("t3_swstrb", s_wstrb, 4'hF);
    chk("t3_rdy1", rdy1, 1'b1);
    chk("t3_rdy0", rdy0, 1'b0);

    // both masters streaming, 2-cycle slave: strict alternation
    do_reset();
    v[0] = 1'b1; v[1] = 1'b1; a[0] = 32'hA0; a[1] = 32'hB0;
    for (int g = 0; g < 4; g++) begin
      #1;
      chk("t2_idle", grant, 2'b00);
      step();
      chk("t2_grant_c1", grant, (g % 2) ? 2'b10 : 2'b01);
      chk("t2_rdy_c1", {rdy1, rdy0}, 2'b00);
      step();
      s_ready = 1'b1;
      s_rdata = 32'(g);
      #1;
      chk("t2_grant_c2", grant, (g % 2) ? 2'b10 : 2'b01);
      chk("t2_rdy_c2", {rdy1, rdy0}, (g % 2) ? 2'b10 : 2'b01);
      chk("t2_saddr", s_addr, (g % 2) ? 32'hB0 : 32'hA0);
      step();
      s_ready = 1'b0;
    end

    // asynchronous reset in the middle of a transfer
    do_reset();
    v[1] = 1'b1;
    step();
    chk("t4_grant", grant, 2'b10);
    resetn = 1'b0;
    #1;
    chk("t4_svalid", s_valid, 1'b0);
    chk("t4_grant_rst", grant, 2'b00);
    chk("t4_rdy", {rdy1, rdy0}, 2'b00);
    @(negedge clk);
    resetn = 1'b1;
    v[0] = 1'b1;
    #1;
    chk("t4_idle", grant, 2'b00);
    step();
    chk("t4_tie", grant, 2'b01);

    // owner abandons its request
    do_reset();
    v[0] = 1'b1;
    step();
    chk("t6_grant", grant, 2'b01);
    v[0] = 1'b0; s_ready = 1'b1;
    #1;
    chk("t6_svalid", s_valid, 1'b0);
    chk("t6_rdy0", rdy0, 1'b0);
    step();
    v[0] = 1'b1; v[1] = 1'b1; s_ready = 1'b0;
    #1;
    chk("t6_idle", grant, 2'b00);
    step();
    chk("t6_tie", grant, 2'b01);

`ifdef ARB_TIMEOUT_EN
    // watchdog fires on the TO-th busy cycle
    do_reset();
    v[0] = 1'b1; a[0] = 32'h8003_0000;
    for (int k = 1; k <= TO; k++) begin
      step();
      chk("t5_rdy", rdy0, 32'(k == TO));
      if (k == TO) chk("t5_rdata", rd0, ERR);
    end
    v[0] = 1'b0;
    step();
    chk("t5_svalid", s_valid, 1'b0);
    chk("t5_err", timeout_err, 1'b1);
    chk("t5_eaddr", err_addr, 32'h8003_0000);
    err_clr = 1'b1;
    step();
    chk("t5_clr", timeout_err, 1'b0);
    err_clr = 1'b0;
`endif

    // randomized traffic against the reference model
    do_reset();
    mbusy = 1'b0; mown = 0; mlast = 1; mtimer = 0;
    merr = 1'b0; merr_addr = 32'h0;
    erdy[0] = 1'b0; erdy[1] = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (v[i]) begin
          if (erdy[i] || $urandom_range(0, 199) == 0) v[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          v[i]  = 1'b1;
          a[i]  = $urandom;
          wd[i] = $urandom;
          ws[i] = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
        end
      end
      s_ready = ($urandom_range(0, 9) < 3);
      s_rdata = $urandom;
      err_clr = ($urandom_range(0, 15) == 0);
      #1;
      ev   = mbusy && v[mown];
      etmo = TMO_EN && ev && !s_ready && (mtimer == TO - 1);
      for (int i = 0; i < 2; i++) begin
        erdy[i] = ev && (mown == i) && (s_ready || etmo);
        erd[i]  = erdy[i] ? (s_ready ? s_rdata : ERR) : 32'h0;
      end
      chk("r_svalid", s_valid, ev);
      if (ev) begin
        chk("r_saddr", s_addr, a[mown]);
        chk("r_swdata", s_wdata, wd[mown]);
        chk("r_swstrb", s_wstrb, ws[mown]);
      end
      chk("r_grant", grant, mbusy ? (mown ? 2'b10 : 2'b01) : 2'b00);
      chk("r_rdy0", rdy0, erdy[0]);
      chk("r_rdy1", rdy1, erdy[1]);
      chk("r_rdata0", rd0, erd[0]);
      chk("r_rdata1", rd1, erd[1]);
      chk("r_err", timeout_err, merr);
      chk("r_eaddr", err_addr, merr_addr);
      if (etmo) begin
        merr = 1'b1;
        merr_addr = a[mown];
      end else if (err_clr) begin
        merr = 1'b0;
      end
      if (!mbusy) begin
        if (v[0] || v[1]) begin
          mbusy  = 1'b1;
          mown   = (v[0] && v[1]) ? 1 - mlast : (v[1] ? 1 : 0);
          mtimer = 0;
        end
      end else if (!ev) begin
        mbusy = 1'b0;
      end else if (erdy[mown]) begin
        mlast = mown;
        mbusy = 1'b0;
      end else begin
        mtimer++;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
